cpu_sequencer: RTL and testbench

- Multi-cycle control core of the Hack-style CPU.
- Fetches 16-bit instructions over a req/ack instruction port and reads or writes data memory over a req/ack data port.
- Drives operands and the 9-bit ALU control field to the extended ALU, then consumes its `out`/`zr`/`ng` for register writeback and jump resolution.
- Owns the A, D and PC registers; sits directly upstream and downstream of the ALU in the top level.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/cpu_jump_cond.sv | 16 +
 rtl/cpu_sequencer.sv | 130 +++++++++++++
 tb/tb_cpu_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants, state encoding and helpers for the Hack-style CPU sequencer.
package cpu_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned ALU_CTL_W = 9;
  localparam int unsigned JMP_W     = 3;
  localparam int unsigned STATE_W   = 3;

  // Instruction field positions
  localparam int unsigned CINSTR_BIT = 15;
  localparam int unsigned ALU_HI     = 14;
  localparam int unsigned ALU_LO     = 6;
  localparam int unsigned A_BIT      = 12;
  localparam int unsigned DEST_A     = 5;
  localparam int unsigned DEST_D     = 4;
  localparam int unsigned DEST_M     = 3;

  // Jump bit positions within instr[2:0]
  localparam int unsigned JMP_LT = 2;
  localparam int unsigned JMP_EQ = 1;
  localparam int unsigned JMP_GT = 0;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_EXEC  = 3'd3;
  localparam state_t ST_STORE = 3'd4;

  // Pending data-memory write captured in EXEC and replayed in STORE
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } store_t;

  // 15-bit program counter increment, wraps 0x7FFF -> 0x0000
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
    return p + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/cpu_jump_cond.sv
// Jump resolution from the ALU flags and the instruction's jump field.
module cpu_jump_cond
  import cpu_pkg::*;
(
  input  logic [JMP_W-1:0] jump,
  input  logic             zr,
  input  logic             ng,
  output logic             take
);

  // lt / eq / gt terms OR-ed together
  assign take = (jump[JMP_LT] & ng) |
                (jump[JMP_EQ] & zr) |
                (jump[JMP_GT] & ~ng & ~zr);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control core: fetch, optional M load, execute, optional M store.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic [ADDR_W-1:0]    pc,
  output logic                 imem_req,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic                 imem_ack,
  input  logic [WORD_W-1:0]    imem_data,
  output logic                 dmem_rd,
  output logic                 dmem_wr,
  output logic [ADDR_W-1:0]    dmem_addr,
  output logic [WORD_W-1:0]    dmem_wdata,
  input  logic [WORD_W-1:0]    dmem_rdata,
  input  logic                 dmem_ack,
  output logic [WORD_W-1:0]    alu_x,
  output logic [WORD_W-1:0]    alu_y,
  output logic [ALU_CTL_W-1:0] alu_instruction,
  input  logic [WORD_W-1:0]    alu_out,
  input  logic                 alu_zr,
  input  logic                 alu_ng
);

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [WORD_W-1:0] a_q, a_n;
  logic [WORD_W-1:0] d_q, d_n;
  logic [WORD_W-1:0] m_q, m_n;
  logic [WORD_W-1:0] instr_q, instr_n;
  store_t            store_q, store_n;
  logic              take;
  state_t            boundary;

  cpu_jump_cond u_jump (
    .jump (instr_q[JMP_W-1:0]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (take)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  // Architectural and staging registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      m_q     <= '0;
      instr_q <= '0;
      store_q <= '0;
    end else begin
      pc_q    <= pc_n;
      a_q     <= a_n;
      d_q     <= d_n;
      m_q     <= m_n;
      instr_q <= instr_n;
      store_q <= store_n;
    end
  end

  // Where an instruction ends: continue fetching or park
  assign boundary = run ? ST_FETCH : ST_IDLE;

  // Next-state and register update decode
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    a_n     = a_q;
    d_n     = d_q;
    m_n     = m_q;
    instr_n = instr_q;
    store_n = store_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_n = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_n = imem_data;
          state_n = (imem_data[CINSTR_BIT] && imem_data[A_BIT]) ? ST_LOAD : ST_EXEC;
        end
      end
      ST_LOAD: begin
        if (dmem_ack) begin
          m_n     = dmem_rdata;
          state_n = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!instr_q[CINSTR_BIT]) begin
          a_n     = {1'b0, instr_q[ADDR_W-1:0]};
          pc_n    = pc_inc(pc_q);
          state_n = boundary;
        end else begin
          // Store address and jump target both come from A before writeback
          store_n = '{addr: a_q[ADDR_W-1:0], data: alu_out};
          if (instr_q[DEST_A]) a_n = alu_out;
          if (instr_q[DEST_D]) d_n = alu_out;
          pc_n    = take ? a_q[ADDR_W-1:0] : pc_inc(pc_q);
          state_n = instr_q[DEST_M] ? ST_STORE : boundary;
        end
      end
      ST_STORE: begin
        if (dmem_ack) state_n = boundary;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Port decode from registered state
  assign pc              = pc_q;
  assign imem_req        = (state_q == ST_FETCH);
  assign imem_addr       = pc_q;
  assign dmem_rd         = (state_q == ST_LOAD);
  assign dmem_wr         = (state_q == ST_STORE);
  assign dmem_addr       = (state_q == ST_STORE) ? store_q.addr : a_q[ADDR_W-1:0];
  assign dmem_wdata      = store_q.data;
  assign alu_x           = d_q;
  assign alu_y           = instr_q[A_BIT] ? m_q : a_q;
  assign alu_instruction = instr_q[ALU_HI:ALU_LO];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: instruction-level model predicts bus events.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [14:0] pc;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic        dmem_rd;
  logic        dmem_wr;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [8:0]  alu_instruction;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [17:0] alu_res;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .alu_x(alu_x), .alu_y(alu_y), .alu_instruction(alu_instruction),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  always #5 clk = ~clk;

  // Hack ALU; modes other than 11 return 0. Result packs {zr, ng, out}.
  function automatic logic [17:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [8:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    if (c[8:7] != 2'b11) o = 16'h0;
    return {(o == 16'h0), o[15], o};
  endfunction

  always_comb alu_res = hack_alu(alu_x, alu_y, alu_instruction);
  assign alu_out = alu_res[15:0];
  assign alu_ng  = alu_res[16];
  assign alu_zr  = alu_res[17];

  localparam int EV_F = 0, EV_R = 1, EV_W = 2, EV_E = 3;

  typedef struct {
    int          kind;
    logic [14:0] addr;
    logic [15:0] data;
    logic [15:0] x;
    logic [15:0] y;
    logic [8:0]  ctl;
    int          delay;
    int          gap;
  } ev_t;

  ev_t         sb[$];
  logic [15:0] imem    [logic [14:0]];
  logic [15:0] mem     [logic [14:0]];
  logic [15:0] ref_mem [logic [14:0]];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Instruction-level reference state
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  int          pend;
  bit          first;
  int          fetch_pushed = 0, fetch_seen = 0;
  int          cyc = 0, last_fetch_cyc = 0, wcnt = 0;
  bit          prev_acked = 0;

  function automatic logic [15:0] rd_assoc_imem(input logic [14:0] k);
    return imem.exists(k) ? imem[k] : 16'hE000;
  endfunction

  function automatic logic [15:0] rd_mem(input logic [14:0] k);
    return mem.exists(k) ? mem[k] : 16'h0000;
  endfunction

  function automatic logic [15:0] rd_ref(input logic [14:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : 16'h0000;
  endfunction

  task automatic model_reset();
    m_a = '0; m_d = '0; m_pc = '0; pend = 0; first = 1;
  endtask

  // Place one instruction at the model pc and queue the bus events it must cause
  task automatic push(input logic [15:0] ins, input int df = 0, input int dl = 0, input int ds = 0);
    ev_t         e;
    logic [15:0] a_old, y;
    logic [17:0] r;
    bit          tk;
    imem[m_pc] = ins;
    e = '{kind: EV_F, addr: m_pc, data: ins, x: 0, y: 0, ctl: 0, delay: df,
          gap: first ? 0 : pend + 1 + df};
    sb.push_back(e);
    fetch_pushed++;
    first = 0;
    if (!ins[15]) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = m_pc + 15'd1;
      pend = 1;
    end else begin
      a_old = m_a;
      pend  = 1;
      if (ins[12]) begin
        e = '{kind: EV_R, addr: a_old[14:0], data: 0, x: 0, y: 0, ctl: 0, delay: dl, gap: 0};
        sb.push_back(e);
        pend += 1 + dl;
      end
      y = ins[12] ? rd_ref(a_old[14:0]) : m_a;
      r = hack_alu(m_d, y, ins[14:6]);
      e = '{kind: EV_E, addr: 0, data: 0, x: m_d, y: y, ctl: ins[14:6], delay: 0, gap: 0};
      sb.push_back(e);
      if (ins[3]) begin
        e = '{kind: EV_W, addr: a_old[14:0], data: r[15:0], x: 0, y: 0, ctl: 0, delay: ds, gap: 0};
        sb.push_back(e);
        ref_mem[a_old[14:0]] = r[15:0];
        pend += 1 + ds;
      end
      if (ins[5]) m_a = r[15:0];
      if (ins[4]) m_d = r[15:0];
      tk   = (ins[2] & r[16]) | (ins[1] & r[17]) | (ins[0] & ~r[16] & ~r[17]);
      m_pc = tk ? a_old[14:0] : m_pc + 15'd1;
    end
  endtask

  // One cycle: respond to requests, compare against the scoreboard head, drive run
  task automatic tick();
    int          kind, expk, nreq;
    logic [14:0] addr;
    bit          acked;
    ev_t         e;
    @(negedge clk);
    cyc++;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    acked    = 0;
    nreq     = int'(imem_req) + int'(dmem_rd) + int'(dmem_wr);
    if (nreq != 0) begin
      check("one_req", 32'(nreq), 32'd1);
      kind = imem_req ? EV_F : (dmem_rd ? EV_R : EV_W);
      expk = (sb.size() == 0) ? 99 : sb[0].kind;
      check("req_kind", 32'(kind), 32'(expk));
      if (kind == expk) begin
        e    = sb[0];
        addr = (kind == EV_F) ? imem_addr : dmem_addr;
        check(kind == EV_F ? "fetch_addr" : (kind == EV_R ? "rd_addr" : "wr_addr"),
              32'(addr), 32'(e.addr));
        if (kind == EV_W) check("wr_data", 32'(dmem_wdata), 32'(e.data));
        if (wcnt == e.delay) begin
          case (kind)
            EV_F: begin
              imem_ack  = 1'b1;
              imem_data = rd_assoc_imem(imem_addr);
              if (e.gap != 0) check("fetch_gap", 32'(cyc - last_fetch_cyc), 32'(e.gap));
              last_fetch_cyc = cyc;
              fetch_seen++;
            end
            EV_R: begin
              dmem_ack   = 1'b1;
              dmem_rdata = rd_mem(dmem_addr);
            end
            default: begin
              dmem_ack = 1'b1;
              mem[dmem_addr] = dmem_wdata;
            end
          endcase
          void'(sb.pop_front());
          wcnt  = 0;
          acked = 1;
        end else begin
          wcnt++;
        end
      end
    end else if (prev_acked && sb.size() != 0 && sb[0].kind == EV_E) begin
      e = sb.pop_front();
      check("exec_alu_ctl", 32'(alu_instruction), 32'(e.ctl));
      check("exec_alu_x", 32'(alu_x), 32'(e.x));
      check("exec_alu_y", 32'(alu_y), 32'(e.y));
    end
    prev_acked = acked;
    run = (fetch_seen < fetch_pushed);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !(fetch_seen == fetch_pushed && sb.size() == 0); i++) tick();
    check("prog_drained", 32'(sb.size()), 32'd0);
    repeat (10) tick();
    check("final_pc", 32'(pc), 32'(m_pc));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) tick();
    sb.delete();
    wcnt = 0; prev_acked = 0; fetch_seen = fetch_pushed;
    rst_n = 1'b1;
    tick();
  endtask

  bit found;

  initial begin
    mem[15'd5]    = 16'h8000; ref_mem[15'd5]    = 16'h8000;
    mem[15'h20]   = 16'h0030; ref_mem[15'h20]   = 16'h0030;
    model_reset();
    repeat (2) tick();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_rd", 32'(dmem_rd), 32'd0);
    check("rst_dmem_wr", 32'(dmem_wr), 32'd0);
    check("rst_alu_x", 32'(alu_x), 32'd0);
    rst_n = 1'b1;
    tick();

    // Program 1: A/C mix, delayed store, load, jumps taken and not taken
    push(16'h1234);
    push(16'h0007);
    push(16'hEC10);             // D=A
    push(16'h4111);
    push(16'hEC50);             // D=!A
    push(16'hE7D0);             // D=D+1 -> 0xBEEF
    push(16'h0064);
    push(16'hE308, 0, 0, 3);    // M=D, ack after 3 waits
    push(16'h0005);
    push(16'hFC10);             // D=M
    push(16'h0040);
    push(16'hEE90);             // D=-1
    push(16'hE304);             // D;JLT taken
    push(16'hEA90, 1);          // D=0
    push(16'h0040);
    push(16'hE304);             // D;JLT not taken
    push(16'h0020);
    push(16'hFDE8, 0, 2, 1);    // AM=M+1, old A addresses both
    push(16'h0060);
    push(16'hE327);             // A=D;JMP to old A
    push(16'h0001, 2);
    wait_done();

    // Reset asserted in the middle of a stalled store
    model_reset();
    reset_dut();
    push(16'h0010);
    push(16'hE308, 0, 0, 50);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (dmem_wr) found = 1;
    end
    check("store_reached", 32'(dmem_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dmem_wr", 32'(dmem_wr), 32'd0);
    check("async_rst_pc", 32'(pc), 32'd0);
    check("async_rst_imem_req", 32'(imem_req), 32'd0);
    sb.delete();
    wcnt = 0; prev_acked = 0; fetch_seen = fetch_pushed;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    dmem_ack = 1'b1;
    tick();
    check("late_ack_ignored", {29'd0, imem_req, dmem_rd, dmem_wr}, 32'd0);
    check("late_ack_pc", 32'(pc), 32'd0);

    // Program 2: restart from 0, jump to 0x7FFF, wrap back to 0
    model_reset();
    push(16'h7FFF);
    push(16'hEA87);             // 0;JMP
    push(16'h0003);             // at 0x7FFF, pc wraps
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
